audio_bus_duplex: RTL and testbench
===================================

AUDIO_BUS_DUPLEX -- requirements
Module: audio_bus_duplex

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, bits per channel sample; frame width FW = 2*SAMPLE_W with left in [FW-1:SAMPLE_W] and right in [SAMPLE_W-1:0].
REQ-002 SHALL have parameter PLAY_DEPTH, default 4, play FIFO frames, power of 2, minimum 2.
REQ-003 SHALL have parameter REC_DEPTH, default 4, record FIFO frames, power of 2, minimum 2.
REQ-004 SHALL have ports:
- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_play_en  in  1  enables the play path.
- i_rec_en  in  1  enables the record path.
- from_adc_left_channel_ready/_data/_valid  out/in/in  1/SAMPLE_W/1  ADC left source.
- from_adc_right_channel_ready/_data/_valid  out/in/in  1/SAMPLE_W/1  ADC right source.
- to_dac_left_channel_data/_valid/_ready  out/out/in  SAMPLE_W/1/1  DAC left sink.
- to_dac_right_channel_data/_valid/_ready  out/out/in  SAMPLE_W/1/1  DAC right sink.
- play_audio_valid/_data/_ready  in/in/out  1/FW/1  play frame input.
- record_audio_ready/_data/_valid  in/out/out  1/FW/1  record frame output.
- o_play_level  out  $clog2(PLAY_DEPTH)+1  play FIFO occupancy.
- o_rec_level  out  $clog2(REC_DEPTH)+1  record FIFO occupancy.
- o_underflow_cnt, o_overflow_cnt  out  16 each  error counters (REQ-020).

Function
REQ-005 SHALL run play and record paths concurrently and independently (full duplex).
REQ-006 SHALL drive play_audio_ready = i_play_en && (o_play_level < PLAY_DEPTH) and write play_audio_data into the play FIFO on each valid&&ready cycle.
REQ-007 SHALL implement the play output FSM with states P_IDLE and P_SEND.
- P_IDLE with FIFO non-empty and i_play_en: pop the head into the DAC register, set both DAC valids, go to P_SEND.
- P_SEND: each DAC valid clears on its own valid&&ready. When both are clear, return to P_IDLE.
REQ-008 SHALL keep each DAC valid and data stable until that channel handshakes, including when i_play_en drops mid-frame; no new pop SHALL occur while i_play_en is low.
REQ-009 SHALL assert both DAC valids no earlier than the second rising edge after an accepted play frame when the FSM is in P_IDLE with the FIFO empty.
REQ-010 SHALL count one underflow per cycle in which the FSM is in P_IDLE, the play FIFO is empty, i_play_en is high, and both DAC readies are high.
REQ-011 SHALL implement the record capture FSM with states R_CAPT and R_PUSH.
- R_CAPT: each ADC ready is high while i_rec_en is high and that channel's half of the hold register is not yet filled. A channel's valid&&ready stores its sample and clears its ready.
- R_CAPT: once both halves are filled, go to R_PUSH.
- R_PUSH (one cycle): if the record FIFO is not full, push the hold frame; if it is full, discard the frame and count one overflow. Then clear the halves and return to R_CAPT.
REQ-012 SHALL evaluate fullness from the registered level, so a push at full is discarded even if a pop occurs in the same cycle.
REQ-013 SHALL present the record FIFO first-word-fall-through: record_audio_valid = (o_rec_level != 0) and record_audio_data = head; the FIFO pops on valid&&ready.
REQ-014 SHALL assert record_audio_valid in the second cycle after the handshake that completes a frame, given an empty FIFO.
REQ-015 SHALL, on i_rec_en low, deassert both ADC readies within one cycle and clear the hold register; FIFO contents SHALL remain readable.
REQ-016 SHALL support simultaneous push and pop on either FIFO, leaving the level unchanged; read and write pointers SHALL wrap modulo depth.

Reset
REQ-017 SHALL, with i_rst high, immediately clear the following regardless of clock: both FSMs to P_IDLE/R_CAPT, FIFO pointers and levels, the hold register, all valids and readies, the DAC data register, and both counters.
REQ-018 SHALL drop an in-progress DAC frame or partial capture on reset mid-operation, with no output glitch after release.
REQ-019 SHALL begin accepting play frames and ADC samples on the first rising edge after reset release.

Configuration
REQ-020 With AUDIO_BUS_ERRCNT_EN defined, o_underflow_cnt and o_overflow_cnt SHALL be 16-bit counters of REQ-010 and REQ-011 events, saturating at 16'hFFFF and cleared only by reset.
REQ-021 Without AUDIO_BUS_ERRCNT_EN, both counter ports SHALL be present and tied to 0, and no counter logic SHALL be synthesised.

Verification
REQ-022 Play: push frames 32'h1111_2222 and 32'h3333_4444 with DAC readies high -> DAC left/right emit 16'h1111/16'h2222 then 16'h3333/16'h4444, in order.
REQ-023 Skewed sink: left ready high, right ready delayed 5 cycles -> left valid clears after 1 cycle; right valid and data held; next frame not presented until right handshakes.
REQ-024 Record: ADC left 16'hABCD, right 16'h1234 arriving 3 cycles apart, record ready low -> record_audio_data 32'hABCD_1234 and o_rec_level = 1.
REQ-025 Overflow: record ready low, 6 frames captured with REC_DEPTH = 4 -> level 4, frames 5 and 6 discarded, o_overflow_cnt = 2 (macro on) or 0 (macro off).
REQ-026 Underflow/reset: play FIFO empty, DAC readies high for 10 cycles with i_play_en high -> o_underflow_cnt = 10; i_rst pulsed mid-frame -> all outputs 0 immediately.
REQ-027 Full FIFO: PLAY_DEPTH = 4, DAC readies low, 5 frames offered -> play_audio_ready low after the 4th, and the 5th is accepted only after the first pop.

Source files
------------

// File: rtl/audio_bus_duplex.sv
// Full-duplex audio bridge: play frames -> split DAC channels, ADC channels -> record frames.
// Optional saturating error counters are built only when AUDIO_BUS_ERRCNT_EN is defined.
module audio_bus_duplex #(
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned PLAY_DEPTH = 4,
  parameter int unsigned REC_DEPTH  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_play_en,
  input  logic                          i_rec_en,
  output logic                          from_adc_left_channel_ready,
  input  logic [SAMPLE_W-1:0]           from_adc_left_channel_data,
  input  logic                          from_adc_left_channel_valid,
  output logic                          from_adc_right_channel_ready,
  input  logic [SAMPLE_W-1:0]           from_adc_right_channel_data,
  input  logic                          from_adc_right_channel_valid,
  output logic [SAMPLE_W-1:0]           to_dac_left_channel_data,
  output logic                          to_dac_left_channel_valid,
  input  logic                          to_dac_left_channel_ready,
  output logic [SAMPLE_W-1:0]           to_dac_right_channel_data,
  output logic                          to_dac_right_channel_valid,
  input  logic                          to_dac_right_channel_ready,
  input  logic                          play_audio_valid,
  input  logic [2*SAMPLE_W-1:0]         play_audio_data,
  output logic                          play_audio_ready,
  input  logic                          record_audio_ready,
  output logic [2*SAMPLE_W-1:0]         record_audio_data,
  output logic                          record_audio_valid,
  output logic [$clog2(PLAY_DEPTH):0]   o_play_level,
  output logic [$clog2(REC_DEPTH):0]    o_rec_level,
  output logic [15:0]                   o_underflow_cnt,
  output logic [15:0]                   o_overflow_cnt
);

  localparam int unsigned FW  = 2 * SAMPLE_W;
  localparam int unsigned PAW = $clog2(PLAY_DEPTH);
  localparam int unsigned PLW = PAW + 1;
  localparam int unsigned RAW = $clog2(REC_DEPTH);
  localparam int unsigned RLW = RAW + 1;

  localparam logic P_IDLE = 1'b0;
  localparam logic P_SEND = 1'b1;
  localparam logic R_CAPT = 1'b0;
  localparam logic R_PUSH = 1'b1;

  // ---------------- play FIFO ----------------
  logic [FW-1:0]  play_mem [PLAY_DEPTH];
  logic [PAW-1:0] play_wr;
  logic [PAW-1:0] play_rd;
  logic [PLW-1:0] play_level;
  logic           play_push;
  logic           play_pop;

  assign play_audio_ready = !i_rst && i_play_en && (play_level < PLW'(PLAY_DEPTH));
  assign play_push        = play_audio_valid && play_audio_ready;
  assign o_play_level     = play_level;

  always_ff @(posedge i_clk) begin
    if (play_push) play_mem[play_wr] <= play_audio_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      play_wr    <= '0;
      play_rd    <= '0;
      play_level <= '0;
    end else begin
      if (play_push) play_wr <= play_wr + PAW'(1);
      if (play_pop)  play_rd <= play_rd + PAW'(1);
      case ({play_push, play_pop})
        2'b10:   play_level <= play_level + PLW'(1);
        2'b01:   play_level <= play_level - PLW'(1);
        default: play_level <= play_level;
      endcase
    end
  end

  // ---------------- play FSM: FIFO head -> DAC register ----------------
  logic          play_state;
  logic          play_state_nx;
  logic [FW-1:0] dac_data;
  logic [FW-1:0] dac_data_nx;
  logic          dac_l_valid_nx;
  logic          dac_r_valid_nx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      play_state                 <= P_IDLE;
      dac_data                   <= '0;
      to_dac_left_channel_valid  <= 1'b0;
      to_dac_right_channel_valid <= 1'b0;
    end else begin
      play_state                 <= play_state_nx;
      dac_data                   <= dac_data_nx;
      to_dac_left_channel_valid  <= dac_l_valid_nx;
      to_dac_right_channel_valid <= dac_r_valid_nx;
    end
  end

  always_comb begin
    play_state_nx  = play_state;
    play_pop       = 1'b0;
    dac_data_nx    = dac_data;
    dac_l_valid_nx = to_dac_left_channel_valid;
    dac_r_valid_nx = to_dac_right_channel_valid;
    case (play_state)
      P_IDLE: begin
        if (i_play_en && (play_level != '0)) begin
          play_pop       = 1'b1;
          dac_data_nx    = play_mem[play_rd];
          dac_l_valid_nx = 1'b1;
          dac_r_valid_nx = 1'b1;
          play_state_nx  = P_SEND;
        end
      end
      P_SEND: begin
        // each channel retires independently; the frame is done when both have
        if (to_dac_left_channel_ready)  dac_l_valid_nx = 1'b0;
        if (to_dac_right_channel_ready) dac_r_valid_nx = 1'b0;
        if (!dac_l_valid_nx && !dac_r_valid_nx) play_state_nx = P_IDLE;
      end
      default: play_state_nx = P_IDLE;
    endcase
  end

  assign to_dac_left_channel_data  = dac_data[FW-1:SAMPLE_W];
  assign to_dac_right_channel_data = dac_data[SAMPLE_W-1:0];

  // ---------------- record capture FSM ----------------
  logic          rec_state;
  logic          rec_state_nx;
  logic [FW-1:0] hold;
  logic [FW-1:0] hold_nx;
  logic          have_l;
  logic          have_l_nx;
  logic          have_r;
  logic          have_r_nx;
  logic          rec_push;
  logic          rec_full;
  logic [RLW-1:0] rec_level;

  assign rec_full = (rec_level == RLW'(REC_DEPTH));
  assign from_adc_left_channel_ready  = !i_rst && (rec_state == R_CAPT) && i_rec_en && !have_l;
  assign from_adc_right_channel_ready = !i_rst && (rec_state == R_CAPT) && i_rec_en && !have_r;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rec_state <= R_CAPT;
      hold      <= '0;
      have_l    <= 1'b0;
      have_r    <= 1'b0;
    end else begin
      rec_state <= rec_state_nx;
      hold      <= hold_nx;
      have_l    <= have_l_nx;
      have_r    <= have_r_nx;
    end
  end

  always_comb begin
    rec_state_nx = rec_state;
    hold_nx      = hold;
    have_l_nx    = have_l;
    have_r_nx    = have_r;
    rec_push     = 1'b0;
    case (rec_state)
      R_CAPT: begin
        if (!i_rec_en) begin
          hold_nx   = '0;
          have_l_nx = 1'b0;
          have_r_nx = 1'b0;
        end else begin
          if (from_adc_left_channel_valid && from_adc_left_channel_ready) begin
            hold_nx[FW-1:SAMPLE_W] = from_adc_left_channel_data;
            have_l_nx              = 1'b1;
          end
          if (from_adc_right_channel_valid && from_adc_right_channel_ready) begin
            hold_nx[SAMPLE_W-1:0] = from_adc_right_channel_data;
            have_r_nx             = 1'b1;
          end
          if (have_l_nx && have_r_nx) rec_state_nx = R_PUSH;
        end
      end
      R_PUSH: begin
        // fullness is judged on the registered level; a full FIFO drops the frame
        rec_push     = !rec_full;
        hold_nx      = '0;
        have_l_nx    = 1'b0;
        have_r_nx    = 1'b0;
        rec_state_nx = R_CAPT;
      end
      default: rec_state_nx = R_CAPT;
    endcase
  end

  // ---------------- record FIFO (first-word-fall-through) ----------------
  logic [FW-1:0]  rec_mem [REC_DEPTH];
  logic [RAW-1:0] rec_wr;
  logic [RAW-1:0] rec_rd;
  logic           rec_pop;

  assign record_audio_valid = (rec_level != '0);
  assign record_audio_data  = record_audio_valid ? rec_mem[rec_rd] : '0;
  assign rec_pop            = record_audio_valid && record_audio_ready;
  assign o_rec_level        = rec_level;

  always_ff @(posedge i_clk) begin
    if (rec_push) rec_mem[rec_wr] <= hold;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rec_wr    <= '0;
      rec_rd    <= '0;
      rec_level <= '0;
    end else begin
      if (rec_push) rec_wr <= rec_wr + RAW'(1);
      if (rec_pop)  rec_rd <= rec_rd + RAW'(1);
      case ({rec_push, rec_pop})
        2'b10:   rec_level <= rec_level + RLW'(1);
        2'b01:   rec_level <= rec_level - RLW'(1);
        default: rec_level <= rec_level;
      endcase
    end
  end

  // ---------------- error counters ----------------
`ifdef AUDIO_BUS_ERRCNT_EN
  logic        underflow_evt;
  logic        overflow_evt;
  logic [15:0] underflow_cnt;
  logic [15:0] overflow_cnt;

  assign underflow_evt = (play_state == P_IDLE) && (play_level == '0) && i_play_en &&
                         to_dac_left_channel_ready && to_dac_right_channel_ready;
  assign overflow_evt  = (rec_state == R_PUSH) && rec_full;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      underflow_cnt <= '0;
      overflow_cnt  <= '0;
    end else begin
      if (underflow_evt && (underflow_cnt != 16'hFFFF)) underflow_cnt <= underflow_cnt + 16'd1;
      if (overflow_evt && (overflow_cnt != 16'hFFFF))   overflow_cnt  <= overflow_cnt + 16'd1;
    end
  end

  assign o_underflow_cnt = underflow_cnt;
  assign o_overflow_cnt  = overflow_cnt;
`else
  assign o_underflow_cnt = '0;
  assign o_overflow_cnt  = '0;
`endif

endmodule

// File: tb/tb_audio_bus_duplex.sv
// Self-checking bench for audio_bus_duplex: directed scenarios plus a randomized duplex run
// scored against queue-based models of frame order, capture pairing and record overflow.
module tb_audio_bus_duplex;

  localparam int unsigned SW = 16;
  localparam int unsigned FW = 32;
  localparam int unsigned PD = 4;
  localparam int unsigned RD = 4;
`ifdef AUDIO_BUS_ERRCNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          play_en;
  logic          rec_en;
  logic          adc_l_ready, adc_l_valid, adc_r_ready, adc_r_valid;
  logic [SW-1:0] adc_l_data, adc_r_data;
  logic [SW-1:0] dac_l_data, dac_r_data;
  logic          dac_l_valid, dac_l_ready, dac_r_valid, dac_r_ready;
  logic          play_valid, play_ready;
  logic [FW-1:0] play_data;
  logic          rec_ready, rec_valid;
  logic [FW-1:0] rec_data;
  logic [2:0]    play_level, rec_level;
  logic [15:0]   ucnt, ocnt;

  audio_bus_duplex #(.SAMPLE_W(SW), .PLAY_DEPTH(PD), .REC_DEPTH(RD)) dut (
    .i_clk(clk), .i_rst(rst), .i_play_en(play_en), .i_rec_en(rec_en),
    .from_adc_left_channel_ready(adc_l_ready), .from_adc_left_channel_data(adc_l_data),
    .from_adc_left_channel_valid(adc_l_valid),
    .from_adc_right_channel_ready(adc_r_ready), .from_adc_right_channel_data(adc_r_data),
    .from_adc_right_channel_valid(adc_r_valid),
    .to_dac_left_channel_data(dac_l_data), .to_dac_left_channel_valid(dac_l_valid),
    .to_dac_left_channel_ready(dac_l_ready),
    .to_dac_right_channel_data(dac_r_data), .to_dac_right_channel_valid(dac_r_valid),
    .to_dac_right_channel_ready(dac_r_ready),
    .play_audio_valid(play_valid), .play_audio_data(play_data), .play_audio_ready(play_ready),
    .record_audio_ready(rec_ready), .record_audio_data(rec_data), .record_audio_valid(rec_valid),
    .o_play_level(play_level), .o_rec_level(rec_level),
    .o_underflow_cnt(ucnt), .o_overflow_cnt(ocnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [SW-1:0] exp_l[$];
  logic [SW-1:0] exp_r[$];
  logic [FW-1:0] exp_rec[$];
  logic [SW-1:0] part_l, part_r;
  bit            part_l_ok, part_r_ok;
  int            model_ovf;
  bit            last_play_hs, last_adc_l_hs, last_adc_r_hs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_flush();
    exp_l.delete();
    exp_r.delete();
    exp_rec.delete();
    part_l_ok = 1'b0;
    part_r_ok = 1'b0;
    model_ovf = 0;
  endtask

  // one clock: observe handshakes mid-cycle, update the model, return just after the edge
  task automatic tick();
    @(negedge clk);
    last_play_hs  = play_valid && play_ready;
    last_adc_l_hs = adc_l_valid && adc_l_ready;
    last_adc_r_hs = adc_r_valid && adc_r_ready;
    if (dac_l_valid && dac_l_ready) begin
      checks++;
      assert (exp_l.size() != 0) else begin
        errors++;
        $error("FAIL dac_l_extra observed=%h expected=none", dac_l_data);
      end
      if (exp_l.size() != 0) chk("dac_l_data", 32'(dac_l_data), 32'(exp_l.pop_front()));
    end
    if (dac_r_valid && dac_r_ready) begin
      checks++;
      assert (exp_r.size() != 0) else begin
        errors++;
        $error("FAIL dac_r_extra observed=%h expected=none", dac_r_data);
      end
      if (exp_r.size() != 0) chk("dac_r_data", 32'(dac_r_data), 32'(exp_r.pop_front()));
    end
    if (last_play_hs) begin
      exp_l.push_back(play_data[FW-1:SW]);
      exp_r.push_back(play_data[SW-1:0]);
    end
    if (rec_valid && rec_ready) begin
      checks++;
      assert (exp_rec.size() != 0) else begin
        errors++;
        $error("FAIL rec_extra observed=%h expected=none", rec_data);
      end
      if (exp_rec.size() != 0) chk("rec_data", rec_data, exp_rec.pop_front());
    end
    if (!rec_en) begin
      part_l_ok = 1'b0;
      part_r_ok = 1'b0;
    end
    if (last_adc_l_hs) begin part_l = adc_l_data; part_l_ok = 1'b1; end
    if (last_adc_r_hs) begin part_r = adc_r_data; part_r_ok = 1'b1; end
    if (part_l_ok && part_r_ok) begin
      if (exp_rec.size() < RD) exp_rec.push_back({part_l, part_r});
      else model_ovf++;
      part_l_ok = 1'b0;
      part_r_ok = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [FW-1:0] d, input int budget, output bit ok);
    play_valid = 1'b1;
    play_data  = d;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = last_play_hs;
    end
    play_valid = 1'b0;
  endtask

  task automatic send_left(input logic [SW-1:0] d, input int budget, output bit ok);
    adc_l_valid = 1'b1;
    adc_l_data  = d;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = last_adc_l_hs;
    end
    adc_l_valid = 1'b0;
  endtask

  task automatic send_right(input logic [SW-1:0] d, input int budget, output bit ok);
    adc_r_valid = 1'b1;
    adc_r_data  = d;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = last_adc_r_hs;
    end
    adc_r_valid = 1'b0;
  endtask

  // asynchronous reset: outputs must clear before any clock edge
  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #1;
    model_flush();
    chk({tag, "_dac_l_valid"}, 32'(dac_l_valid), 0);
    chk({tag, "_dac_r_valid"}, 32'(dac_r_valid), 0);
    chk({tag, "_dac_l_data"},  32'(dac_l_data), 0);
    chk({tag, "_dac_r_data"},  32'(dac_r_data), 0);
    chk({tag, "_play_ready"},  32'(play_ready), 0);
    chk({tag, "_adc_l_ready"}, 32'(adc_l_ready), 0);
    chk({tag, "_adc_r_ready"}, 32'(adc_r_ready), 0);
    chk({tag, "_rec_valid"},   32'(rec_valid), 0);
    chk({tag, "_rec_data"},    rec_data, 0);
    chk({tag, "_play_level"},  32'(play_level), 0);
    chk({tag, "_rec_level"},   32'(rec_level), 0);
    chk({tag, "_ucnt"},        32'(ucnt), 0);
    chk({tag, "_ocnt"},        32'(ocnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    logic [FW-1:0] f;

    rst = 1'b1; play_en = 1'b0; rec_en = 1'b0;
    adc_l_valid = 1'b0; adc_r_valid = 1'b0; adc_l_data = '0; adc_r_data = '0;
    dac_l_ready = 1'b0; dac_r_ready = 1'b0;
    play_valid = 1'b0; play_data = '0; rec_ready = 1'b0;
    model_flush();
    #3;
    apply_reset("por");

    // in-order playback with readies high; first DAC valid one edge after the accepting edge
    play_en = 1'b1; dac_l_ready = 1'b1; dac_r_ready = 1'b1;
    push_frame(32'h1111_2222, 4, ok);
    chk("play1_accept", 32'(ok), 1);
    chk("play1_not_early", 32'(dac_l_valid), 0);
    tick();
    chk("play1_valid", 32'({dac_l_valid, dac_r_valid}), 3);
    chk("play1_left", 32'(dac_l_data), 32'h1111);
    chk("play1_right", 32'(dac_r_data), 32'h2222);
    push_frame(32'h3333_4444, 4, ok);
    chk("play2_accept", 32'(ok), 1);
    repeat (6) tick();
    chk("play_drained", 32'(exp_l.size() + exp_r.size()), 0);

    // skewed sink: right channel stalls, left must not be re-presented
    dac_l_ready = 1'b0; dac_r_ready = 1'b0;
    push_frame(32'hAAAA_BBBB, 4, ok);
    push_frame(32'hCCCC_DDDD, 4, ok);
    chk("skew_valid", 32'({dac_l_valid, dac_r_valid}), 3);
    dac_l_ready = 1'b1;
    tick();
    chk("skew_left_cleared", 32'(dac_l_valid), 0);
    for (int i = 0; i < 4; i++) begin
      chk("skew_right_held", 32'({dac_r_valid, dac_r_data}), 32'h1_BBBB);
      chk("skew_left_idle", 32'(dac_l_valid), 0);
      tick();
    end
    dac_r_ready = 1'b1;
    tick();
    chk("skew_right_cleared", 32'(dac_r_valid), 0);
    dac_l_ready = 1'b0; dac_r_ready = 1'b0;
    tick();
    chk("skew_next_frame", 32'({dac_l_valid, dac_l_data}), 32'h1_CCCC);
    dac_l_ready = 1'b1; dac_r_ready = 1'b1;
    repeat (4) tick();
    chk("skew_drained", 32'(exp_l.size() + exp_r.size()), 0);
    play_en = 1'b0; dac_l_ready = 1'b0; dac_r_ready = 1'b0;

    // record pairing with channels 3 cycles apart; valid appears in 2nd cycle after completion
    apply_reset("rst_rec");
    rec_en = 1'b1; rec_ready = 1'b0;
    send_left(16'hABCD, 4, ok);
    chk("rec_left_accept", 32'(ok), 1);
    chk("rec_left_ready_cleared", 32'(adc_l_ready), 0);
    repeat (2) tick();
    send_right(16'h1234, 4, ok);
    chk("rec_right_accept", 32'(ok), 1);
    chk("rec_not_early", 32'(rec_valid), 0);
    tick();
    chk("rec_valid", 32'(rec_valid), 1);
    chk("rec_frame", rec_data, 32'hABCD_1234);
    chk("rec_level1", 32'(rec_level), 1);
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
    chk("rec_level0", 32'(rec_level), 0);

    // overflow: six frames into a depth-4 FIFO with no consumer
    apply_reset("rst_ovf");
    rec_en = 1'b1; rec_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      adc_l_valid = 1'b1; adc_r_valid = 1'b1;
      adc_l_data = SW'($urandom); adc_r_data = SW'($urandom);
      tick();
      chk("ovf_capture", 32'({last_adc_l_hs, last_adc_r_hs}), 3);
      adc_l_valid = 1'b0; adc_r_valid = 1'b0;
      tick();
    end
    tick();
    chk("ovf_level", 32'(rec_level), RD);
    chk("ovf_count", 32'(ocnt), CNT_ON ? 32'(model_ovf) : 0);
    rec_ready = 1'b1;
    repeat (6) tick();
    chk("ovf_drained", 32'(exp_rec.size()), 0);
    chk("ovf_level0", 32'(rec_level), 0);
    rec_ready = 1'b0; rec_en = 1'b0;

    // underflow: empty FIFO, enabled, both readies high for a fixed number of cycles
    apply_reset("rst_unf");
    play_en = 1'b1; dac_l_ready = 1'b1; dac_r_ready = 1'b1;
    n = 10;
    repeat (n) tick();
    dac_l_ready = 1'b0; dac_r_ready = 1'b0;
    chk("unf_count", 32'(ucnt), CNT_ON ? 32'(n) : 0);

    // reset mid-frame and mid-capture, then acceptance on the first edge after release
    push_frame(32'h5555_6666, 4, ok);
    tick();
    chk("mid_frame_valid", 32'(dac_l_valid), 1);
    rec_en = 1'b1;
    send_left(16'h7777, 4, ok);
    apply_reset("rst_mid");
    chk("post_rst_no_glitch", 32'({dac_l_valid, dac_r_valid}), 0);
    push_frame(32'h7777_8888, 1, ok);
    chk("post_rst_play_first_edge", 32'(ok), 1);
    send_left(16'h0F0F, 1, ok);
    chk("post_rst_adc_first_edge", 32'(ok), 1);
    rec_en = 1'b0;
    dac_l_ready = 1'b1; dac_r_ready = 1'b1;
    repeat (4) tick();
    chk("post_rst_drained", 32'(exp_l.size()), 0);

    // full play FIFO behind a stalled DAC frame
    apply_reset("rst_full");
    play_en = 1'b1; dac_l_ready = 1'b0; dac_r_ready = 1'b0;
    push_frame(32'h0000_0001, 4, ok);
    tick();
    for (int i = 1; i <= 4; i++) begin
      f = FW'(i * 32'h0101_0101);
      push_frame(f, 4, ok);
      chk("full_accept", 32'(ok), 1);
    end
    chk("full_ready_low", 32'(play_ready), 0);
    chk("full_level", 32'(play_level), PD);
    play_valid = 1'b1; play_data = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_fifth_held", 32'(last_play_hs), 0);
    end
    dac_l_ready = 1'b1; dac_r_ready = 1'b1;
    tick();
    chk("full_fifth_before_pop", 32'(last_play_hs), 0);
    dac_l_ready = 1'b0; dac_r_ready = 1'b0;
    n = 0; ok = 1'b0;
    while (n < 4 && !ok) begin
      tick();
      n++;
      ok = last_play_hs;
    end
    play_valid = 1'b0;
    chk("full_fifth_accepted", 32'(ok), 1);
    chk("full_fifth_after_pop", 32'(n), 2);
    dac_l_ready = 1'b1; dac_r_ready = 1'b1;
    repeat (14) tick();
    chk("full_drained", 32'(exp_l.size() + exp_r.size()), 0);

    // randomized duplex traffic against the queue models
    apply_reset("rst_rand");
    rec_ready = 1'b1;
    for (int i = 0; i < 600; i++) begin
      play_en     = ($urandom_range(0, 15) != 0);
      rec_en      = ($urandom_range(0, 15) != 0);
      play_valid  = $urandom_range(0, 1) == 1;
      play_data   = $urandom;
      dac_l_ready = $urandom_range(0, 2) != 0;
      dac_r_ready = $urandom_range(0, 2) != 0;
      adc_l_valid = $urandom_range(0, 1) == 1;
      adc_r_valid = $urandom_range(0, 1) == 1;
      adc_l_data  = SW'($urandom);
      adc_r_data  = SW'($urandom);
      tick();
    end
    play_valid = 1'b0; adc_l_valid = 1'b0; adc_r_valid = 1'b0;
    play_en = 1'b1; dac_l_ready = 1'b1; dac_r_ready = 1'b1;
    repeat (20) tick();
    chk("rand_play_drained", 32'(exp_l.size() + exp_r.size()), 0);
    chk("rand_rec_drained", 32'(exp_rec.size()), 0);
    chk("rand_play_level", 32'(play_level), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
